// File: rtl/mac_frame_accumulator.sv
// mac_frame_accumulator
//
// Sums ACC_LEN consecutive accepted samples of the upstream MAC result stream
// into one frame total of OUT_W = 2*bus_width+GUARD bits. The total is handed
// to the consumer on a valid/ready handshake together with a sticky
// per-frame overflow flag. While a total is waiting, in_ready_o is low, so the
// upstream sample source is back-pressured.
//
// Build option:
//   MAC_FRAME_ACC_SATURATE_EN  defined   -> accumulator clamps to 2^OUT_W-1 on overflow
//                              undefined -> accumulator wraps modulo 2^OUT_W
//   overflow_o behaves the same in both builds.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   clear_i      synchronous frame abort (highest priority after reset)
//   in_valid_i   data_in_i carries a sample this cycle
//   data_in_i    unsigned MAC result, 2*bus_width bits
//   in_ready_o   block accepts a sample this cycle (registered)
//   sum_out_o    unsigned frame total, OUT_W bits (registered)
//   sum_valid_o  sum_out_o / overflow_o valid
//   sum_ready_i  consumer takes the frame total
//   overflow_o   frame exceeded 2^OUT_W-1 at least once
//
// States:
//   state   | meaning
//   S_IDLE  | no samples in the current frame, acc and cnt are zero
//   S_ACCUM | 1..ACC_LEN-1 samples summed into acc
//   S_DONE  | frame total presented, waiting for sum_ready_i
//
// GUARD must be at least 1.

module mac_frame_accumulator #(
  parameter int bus_width = 8,
  parameter int ACC_LEN   = 4,
  parameter int GUARD     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic                         in_valid_i,
  input  logic [2*bus_width-1:0]       data_in_i,
  output logic                         in_ready_o,
  output logic [2*bus_width+GUARD-1:0] sum_out_o,
  output logic                         sum_valid_o,
  input  logic                         sum_ready_i,
  output logic                         overflow_o
);

  localparam int IN_W  = 2 * bus_width;
  localparam int OUT_W = IN_W + GUARD;
  localparam int CNT_W = $clog2(ACC_LEN + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  logic [OUT_W:0]   add_full;
  logic [OUT_W-1:0] add_res;
  logic             carry;
  logic             accept;

  // One extra bit on the adder so the carry out of the OUT_W-bit total is visible.
  assign add_full = {1'b0, acc_q} + {{(GUARD + 1){1'b0}}, data_in_i};
  assign carry    = add_full[OUT_W];
  assign accept   = in_valid_i & ready_q;

`ifdef MAC_FRAME_ACC_SATURATE_EN
  // Once clamped, any further nonzero sample carries again, so acc stays at max.
  assign add_res = carry ? {OUT_W{1'b1}} : add_full[OUT_W-1:0];
`else
  assign add_res = add_full[OUT_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    if (clear_i) begin
      // Abort wins over everything, including a same-cycle handshake.
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            acc_d   = {{GUARD{1'b0}}, data_in_i};
            cnt_d   = CNT_W'(1);
            state_d = S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc_d = add_res;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | carry;
            if (cnt_q == LAST_CNT) begin
              // Total is captured from the adder so it is visible in the
              // same period that the last sample is accepted.
              sum_d   = add_res;
              valid_d = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (sum_ready_i) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end

    // Registered ready: low exactly while a total is being presented.
    ready_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign sum_out_o   = sum_q;
  assign sum_valid_o = valid_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_mac_frame_accumulator.sv
module tb_mac_frame_accumulator;

  localparam int AL = 4;
  localparam int WA = 18;   // GUARD=2 instance
  localparam int WB = 17;   // GUARD=1 instance
`ifdef MAC_FRAME_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        sum_ready = 1'b0;
  logic [15:0] data_in = '0;

  logic        rdy_a, sv_a, ovf_a;
  logic [17:0] sum_a;
  logic        rdy_b, sv_b, ovf_b;
  logic [16:0] sum_b;

  always #5 clk = ~clk;

  mac_frame_accumulator #(.bus_width(8), .ACC_LEN(AL), .GUARD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .data_in_i(data_in), .in_ready_o(rdy_a), .sum_out_o(sum_a),
    .sum_valid_o(sv_a), .sum_ready_i(sum_ready), .overflow_o(ovf_a)
  );

  mac_frame_accumulator #(.bus_width(8), .ACC_LEN(AL), .GUARD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .data_in_i(data_in), .in_ready_o(rdy_b), .sum_out_o(sum_b),
    .sum_valid_o(sv_b), .sum_ready_i(sum_ready), .overflow_o(ovf_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the samples of the open frame are kept in a queue and the
  // frame total is recomputed from them with plain integer arithmetic.
  longint m_q[$];
  bit     m_rdy, m_pend, m_ovf_a, m_ovf_b;
  longint m_sum_a, m_sum_b;

  function automatic void frame_total(input int w, output longint tot, output bit ov);
    longint lim;
    lim = longint'(1) << w;
    tot = 0;
    ov  = 1'b0;
    foreach (m_q[i]) begin
      tot += m_q[i];
      if (tot >= lim) begin
        ov  = 1'b1;
        tot = SAT ? (lim - 1) : (tot - lim);
      end
    end
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rdy = 0; m_pend = 0; m_ovf_a = 0; m_ovf_b = 0;
    m_sum_a = 0; m_sum_b = 0;
  endtask

  task automatic model_edge();
    longint t;
    bit     o;
    if (clear) begin
      m_q.delete();
      m_pend = 0; m_ovf_a = 0; m_ovf_b = 0;
    end else if (m_pend) begin
      if (sum_ready) begin
        m_pend = 0; m_ovf_a = 0; m_ovf_b = 0;
      end
    end else if (in_valid && m_rdy) begin
      m_q.push_back(longint'(data_in));
      frame_total(WA, t, o);
      m_ovf_a = o;
      if (m_q.size() == AL) m_sum_a = t;
      frame_total(WB, t, o);
      m_ovf_b = o;
      if (m_q.size() == AL) m_sum_b = t;
      if (m_q.size() == AL) begin
        m_pend = 1;
        m_q.delete();
      end
    end
    m_rdy = !m_pend;
  endtask

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic check_all();
    check("a.in_ready",  longint'(rdy_a), longint'(m_rdy));
    check("a.sum_valid", longint'(sv_a),  longint'(m_pend));
    check("a.sum_out",   longint'(sum_a), m_sum_a);
    check("a.overflow",  longint'(ovf_a), longint'(m_ovf_a));
    check("b.in_ready",  longint'(rdy_b), longint'(m_rdy));
    check("b.sum_valid", longint'(sv_b),  longint'(m_pend));
    check("b.sum_out",   longint'(sum_b), m_sum_b);
    check("b.overflow",  longint'(ovf_b), longint'(m_ovf_b));
  endtask

  task automatic drive(input bit clr, input bit iv, input int d, input bit sr);
    clear     = clr;
    in_valid  = iv;
    data_in   = 16'(d);
    sum_ready = sr;
  endtask

  // Clock edge: model sees the inputs that were stable at the edge, outputs
  // are checked 1 time unit later, and the caller then drives new inputs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  typedef struct {
    bit          clr;
    bit          iv;
    int          d;
    bit          sr;
    bit          e_rdy;
    bit          e_sv;
    longint      e_sum;
    bit          e_ovf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // Basic frame 100+200+300+400, sum_ready held high.
    tbl[0] = '{0, 1, 100, 1, 1, 0, 0,    0};
    tbl[1] = '{0, 1, 200, 1, 1, 0, 0,    0};
    tbl[2] = '{0, 1, 300, 1, 1, 0, 0,    0};
    tbl[3] = '{0, 1, 400, 1, 0, 1, 1000, 0};
    tbl[4] = '{0, 1, 5,   1, 1, 0, 1000, 0};  // sample offered in DONE is not taken
    tbl[5] = '{0, 0, 0,   1, 1, 0, 1000, 0};

    model_reset();
    #12;
    check_all();                       // outputs during reset
    rst_n = 1'b1;                      // released mid-period
    #1;
    check("rst.in_ready_before_edge", longint'(rdy_a), 0);
    step();                            // in_ready rises on first edge
    check("rst.in_ready_after_edge", longint'(rdy_a), 1);

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].iv, tbl[i].d, tbl[i].sr);
      step();
      check($sformatf("tbl[%0d].in_ready", i),  longint'(rdy_a), longint'(tbl[i].e_rdy));
      check($sformatf("tbl[%0d].sum_valid", i), longint'(sv_a),  longint'(tbl[i].e_sv));
      check($sformatf("tbl[%0d].sum_out", i),   longint'(sum_a), tbl[i].e_sum);
      check($sformatf("tbl[%0d].overflow", i),  longint'(ovf_a), longint'(tbl[i].e_ovf));
    end

    // Gapped 65535 x4 with back-pressure; dut_b (17 bits) overflows.
    for (int k = 0; k < AL; k++) begin
      drive(0, 0, 0, 0);
      step();
      drive(0, 1, 65535, 0);
      step();
    end
    check("gap.sum_valid", longint'(sv_a), 1);
    check("ovf.flag_b", longint'(ovf_b), 1);
    check("ovf.sum_b", longint'(sum_b), SAT ? 131071 : 131068);
    check("gap.overflow_a", longint'(ovf_a), 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 65535, 0);           // upstream keeps offering its sample
      step();
      check("bp.sum_out", longint'(sum_a), 262140);
      check("bp.sum_valid", longint'(sv_a), 1);
      check("bp.in_ready", longint'(rdy_a), 0);
      check("bp.overflow_b", longint'(ovf_b), 1);
    end
    drive(0, 1, 65535, 1);
    step();                            // handshake edge
    check("hs.in_ready", longint'(rdy_a), 1);
    check("hs.sum_valid", longint'(sv_a), 0);
    check("hs.overflow_b", longint'(ovf_b), 0);
    drive(0, 1, 65535, 1);
    step();                            // first sample of next frame taken here

    // Clear mid-frame: abandon partial frame, sample offered with clear is dropped.
    drive(1, 0, 0, 0); step();
    drive(0, 1, 5, 0); step();
    drive(0, 1, 7, 0); step();
    drive(1, 1, 99, 0); step();
    check("clr.in_ready", longint'(rdy_a), 1);
    drive(0, 1, 1, 1); step();
    drive(0, 1, 2, 1); step();
    drive(0, 1, 3, 1); step();
    drive(0, 1, 4, 1); step();
    check("clr.sum_out", longint'(sum_a), 10);
    check("clr.overflow", longint'(ovf_a), 0);
    drive(0, 0, 0, 1); step();

    // Clear in DONE together with sum_ready.
    drive(0, 1, 10, 0); step();
    drive(0, 1, 20, 0); step();
    drive(0, 1, 30, 0); step();
    drive(0, 1, 40, 0); step();
    check("cdone.pre_valid", longint'(sv_a), 1);
    drive(1, 0, 0, 1); step();
    check("cdone.sum_valid", longint'(sv_a), 0);
    check("cdone.in_ready", longint'(rdy_a), 1);
    drive(0, 0, 0, 0); step();

    // Reset mid-frame after 3 samples.
    drive(0, 1, 1000, 0); step();
    drive(0, 1, 2000, 0); step();
    drive(0, 1, 3000, 0); step();
    drive(0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("mrst.in_ready", longint'(rdy_a), 0);
    #2;
    rst_n = 1'b1;
    #1;
    check("mrst.in_ready_hold", longint'(rdy_b), 0);
    step();
    check("mrst.in_ready_up", longint'(rdy_a), 1);
    drive(0, 1, 11, 1); step();
    drive(0, 1, 22, 1); step();
    drive(0, 1, 33, 1); step();
    drive(0, 1, 44, 1); step();
    check("mrst.sum_out", longint'(sum_a), 110);
    drive(0, 0, 0, 1); step();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? 65535 : int'($urandom_range(0, 65535));
      drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 7), d,
            ($urandom_range(0, 1) == 1));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_frame_accumulator.md
# mac_frame_accumulator

- Downstream stage of the multiply-add register.
- Consumes its `2*bus_width` result stream and sums `ACC_LEN` consecutive accepted samples into one frame total with guard bits.
- Presents each total on a valid/ready output handshake, with a per-frame overflow flag.
- Sits between the MAC register and the frame-result consumer, and back-pressures the upstream sample source through `in_ready`.

## Interface
- `bus_width`, 8: operand width of the upstream MAC; input sample width is `2*bus_width`.
- `ACC_LEN`, 4: samples per frame, legal range 2..256.
- `GUARD`, 2: extra accumulator bits; `OUT_W = 2*bus_width+GUARD`.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous frame abort.
- `in_valid`  in  1  `data_in` carries a sample this cycle.
- `data_in`  in  `2*bus_width`  unsigned MAC result.
- `in_ready`  out  1  block accepts a sample this cycle.
- `sum_out`  out  `OUT_W`  unsigned frame total.
- `sum_valid`  out  1  `sum_out` / `overflow` valid.
- `sum_ready`  in  1  consumer takes the frame total.
- `overflow`  out  1  the frame exceeded `2^OUT_W-1` at least once.

## Operation
- **Acceptance:** a sample is accepted on a posedge with `in_valid && in_ready`. `data_in` is sampled on posedge only; upstream updates on negedge, so it is stable by then.
- **FSM states:** IDLE, ACCUM, DONE.
  - IDLE: `acc=0`, `cnt=0`. An accepted sample loads `acc=data_in`, sets `cnt=1`, and moves to ACCUM.
  - ACCUM: each accepted sample adds `data_in` to `acc` and increments `cnt`. When the `ACC_LEN`-th sample is accepted, move to DONE.
  - DONE: `sum_valid=1`, `in_ready=0`. On `sum_ready`, return to IDLE with `acc`, `cnt` and `overflow` cleared.
- **No-sample cycles:** `in_valid=0` in IDLE or ACCUM holds all state. There is no timeout.
- **Arithmetic:** `acc + data_in` is formed at `OUT_W+1` bits. A carry into bit `OUT_W` sets sticky `overflow`. The stored result is governed by the Configuration section.
- **Output registers:** `sum_out` is a registered copy of `acc`, updated on entry to DONE and held stable while `sum_valid=1`. It keeps its last value after handoff.
- **`clear`:**
  - Highest priority after reset.
  - Forces IDLE and zeroes `acc`, `cnt`, `overflow` and `sum_valid`.
  - A pending unconsumed total is discarded.
  - A sample presented in the same cycle is not accepted.
- **`clear` with `sum_ready`:** `clear` wins. The handshake is void.
- **`in_valid` in DONE:** ignored, because `in_ready=0`. Upstream must hold its sample.

## Timing
- **Reset:** while `rst_n=0`, `in_ready=0`, `sum_valid=0`, `sum_out=0`, `overflow=0`, state is IDLE, `cnt=0`, `acc=0`.
- **`in_ready` after reset:** registered. It rises on the first posedge after `rst_n` deasserts.
- **Reset mid-frame:** an asynchronous `rst_n` assertion drops every output to its reset value immediately. The partial frame is lost.
- **Latency:** `sum_valid` rises on the posedge that accepts the `ACC_LEN`-th sample. The total is visible in the same clock period.
- **`in_ready` around DONE:**
  - Falls together with `sum_valid`, registered from the same edge.
  - Rises on the posedge where `sum_ready && sum_valid`.
  - The first sample of the next frame is accepted one cycle later.
- **Throughput:** minimum `ACC_LEN+1` cycles per frame with `sum_ready` held high.
- **Back-pressure:** `sum_valid` stays asserted and `sum_out` / `overflow` stay stable for as long as `sum_ready=0`.

## Configuration
- Macro: `MAC_FRAME_ACC_SATURATE_EN`.
- **Defined:** on overflow `acc` clamps to `2^OUT_W-1` and stays there for the rest of the frame. Later additions do not wrap.
- **Undefined:** `acc` wraps modulo `2^OUT_W`.
- `overflow` reporting is identical in both builds.

## Test plan
- **Basic frame** (`bus_width=8`, `ACC_LEN=4`, `GUARD=2`): samples 100, 200, 300, 400 back-to-back, `sum_ready=1` -> `sum_out=1000`, `overflow=0`, `sum_valid` high for exactly 1 cycle, `in_ready` low 1 cycle.
- **Gapped input and back-pressure:** samples 65535 x4 with `in_valid` gaps, `sum_ready=0` for 5 cycles after DONE -> `sum_out=262140` held stable for 5 cycles, `in_ready=0` throughout, next frame starts the cycle after the handshake.
- **Overflow** (`GUARD=1`, `OUT_W=17`): samples 65535 x4 -> `overflow=1`; `sum_out=131071` with the macro defined, `sum_out=131068` without it.
- **`clear` mid-frame:** `clear` after 2 samples (5, 7), then samples 1, 2, 3, 4 -> `sum_out=10`, `overflow=0`.
- **`clear` in DONE:** `clear` in DONE together with `sum_ready=1` -> `sum_valid=0` next edge, no handshake counted, `in_ready=1`.
- **Reset mid-frame:** `rst_n` pulsed low after 3 samples -> all outputs 0 immediately, `in_ready` returns 1 one posedge after release, next full frame totals correctly.
